// File: rtl/riscv5_pipe_cpu.sv
// Five-stage in-order RV32 subset core (IF/ID/EX/MEM/WB); optional PERF_CNT_EN adds stall/flush counters.
// Latency: fetch to register write is 5 cycles; branches resolve in ID with a 1-cycle taken penalty.
// Backpressure: start_i=0 freezes every stage; a load-use hazard holds PC and IF/ID for one cycle.
module riscv5_pipe_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [31:0] pc_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL} alu_op_t;
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    use_imm;
        alu_op_t alu_op;
    } ctrl_t;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [32];

    logic [31:0] pc;
    logic [31:0] ifid_pc, ifid_instr;
    ctrl_t       idex_ctrl;
    logic [31:0] idex_a, idex_b, idex_imm;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic        exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg;
    logic [31:0] exmem_alu, exmem_sd;
    logic [4:0]  exmem_rd;
    logic        memwb_reg_write, memwb_mem_to_reg;
    logic [31:0] memwb_alu, memwb_ld;
    logic [4:0]  memwb_rd;

    logic [6:0]  id_op, id_f7;
    logic [2:0]  id_f3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    ctrl_t       id_ctrl;
    logic [31:0] id_imm, id_rd1, id_rd2, br_target, wb_val;
    logic        is_beq, branch_taken, load_use;
    logic [31:0] fwd_a, fwd_b, op_b, alu_y;

    assign pc_o   = pc;
    assign id_op  = ifid_instr[6:0];
    assign id_rd  = ifid_instr[11:7];
    assign id_f3  = ifid_instr[14:12];
    assign id_rs1 = ifid_instr[19:15];
    assign id_rs2 = ifid_instr[24:20];
    assign id_f7  = ifid_instr[31:25];
    assign wb_val = memwb_mem_to_reg ? memwb_ld : memwb_alu;

    always_comb begin
        id_ctrl = '0;
        id_imm  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
        is_beq  = 1'b0;
        case (id_op)
            7'b0110011: begin
                id_ctrl.reg_write = 1'b1;
                if (id_f7 == 7'b0000000 && id_f3 == 3'b111)      id_ctrl.alu_op = ALU_AND;
                else if (id_f7 == 7'b0000000 && id_f3 == 3'b100) id_ctrl.alu_op = ALU_XOR;
                else if (id_f7 == 7'b0000000 && id_f3 == 3'b001) id_ctrl.alu_op = ALU_SLL;
                else if (id_f7 == 7'b0000000 && id_f3 == 3'b000) id_ctrl.alu_op = ALU_ADD;
                else if (id_f7 == 7'b0100000 && id_f3 == 3'b000) id_ctrl.alu_op = ALU_SUB;
                else if (id_f7 == 7'b0000001 && id_f3 == 3'b000) id_ctrl.alu_op = ALU_MUL;
                else id_ctrl.reg_write = 1'b0;
            end
            7'b0010011: begin
                id_ctrl.use_imm = 1'b1;
                if (id_f3 == 3'b000) begin
                    id_ctrl.reg_write = 1'b1;
                end else if (id_f3 == 3'b101 && id_f7 == 7'b0100000) begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_op    = ALU_SRA;
                end
            end
            7'b0000011: if (id_f3 == 3'b010) begin
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.use_imm    = 1'b1;
            end
            7'b0100011: if (id_f3 == 3'b010) begin
                id_ctrl.mem_write = 1'b1;
                id_ctrl.use_imm   = 1'b1;
                id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            end
            7'b1100011: is_beq = (id_f3 == 3'b000);
            default: ;
        endcase
    end

    // Register read with write-through from WB; x0 is hardwired to zero.
    always_comb begin
        if (id_rs1 == 5'd0)                              id_rd1 = '0;
        else if (memwb_reg_write && memwb_rd == id_rs1)  id_rd1 = wb_val;
        else                                             id_rd1 = rf[id_rs1];
        if (id_rs2 == 5'd0)                              id_rd2 = '0;
        else if (memwb_reg_write && memwb_rd == id_rs2)  id_rd2 = wb_val;
        else                                             id_rd2 = rf[id_rs2];
    end

    assign br_target    = ifid_pc + {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                                     ifid_instr[30:25], ifid_instr[11:8], 1'b0};
    assign branch_taken = is_beq && (id_rd1 == id_rd2);
    assign load_use     = idex_ctrl.mem_read && (idex_rd != 5'd0) &&
                          ((idex_rd == id_rs1) || (idex_rd == id_rs2));

    always_comb begin
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs1)       fwd_a = exmem_alu;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs1)  fwd_a = wb_val;
        else                                                                   fwd_a = idex_a;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs2)       fwd_b = exmem_alu;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs2)  fwd_b = wb_val;
        else                                                                   fwd_b = idex_b;
    end

    assign op_b = idex_ctrl.use_imm ? idex_imm : fwd_b;

    always_comb begin
        alu_y = fwd_a + op_b;
        case (idex_ctrl.alu_op)
            ALU_SUB: alu_y = fwd_a - op_b;
            ALU_AND: alu_y = fwd_a & op_b;
            ALU_XOR: alu_y = fwd_a ^ op_b;
            ALU_SLL: alu_y = fwd_a << op_b[4:0];
            ALU_SRA: alu_y = $signed(fwd_a) >>> op_b[4:0];
            ALU_MUL: alu_y = fwd_a * op_b;
            default: alu_y = fwd_a + op_b;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc <= '0;  ifid_pc <= '0;  ifid_instr <= '0;
            idex_ctrl <= '0;  idex_a <= '0;  idex_b <= '0;  idex_imm <= '0;
            idex_rs1 <= '0;  idex_rs2 <= '0;  idex_rd <= '0;
            exmem_reg_write <= 1'b0;  exmem_mem_read <= 1'b0;  exmem_mem_write <= 1'b0;
            exmem_mem_to_reg <= 1'b0;  exmem_alu <= '0;  exmem_sd <= '0;  exmem_rd <= '0;
            memwb_reg_write <= 1'b0;  memwb_mem_to_reg <= 1'b0;
            memwb_alu <= '0;  memwb_ld <= '0;  memwb_rd <= '0;
        end else if (start_i) begin
            // A load-use stall outranks a taken branch; the branch is re-evaluated next cycle.
            if (!load_use) begin
                pc         <= branch_taken ? br_target : pc + 32'd4;
                ifid_pc    <= branch_taken ? '0 : pc;
                ifid_instr <= branch_taken ? '0 : imem[pc[IW+1:2]];
            end
            if (load_use) begin
                idex_ctrl <= '0;  idex_a <= '0;  idex_b <= '0;  idex_imm <= '0;
                idex_rs1 <= '0;  idex_rs2 <= '0;  idex_rd <= '0;
            end else begin
                idex_ctrl <= id_ctrl;  idex_a <= id_rd1;  idex_b <= id_rd2;  idex_imm <= id_imm;
                idex_rs1 <= id_rs1;  idex_rs2 <= id_rs2;  idex_rd <= id_rd;
            end
            exmem_reg_write  <= idex_ctrl.reg_write;
            exmem_mem_read   <= idex_ctrl.mem_read;
            exmem_mem_write  <= idex_ctrl.mem_write;
            exmem_mem_to_reg <= idex_ctrl.mem_to_reg;
            exmem_alu        <= alu_y;
            exmem_sd         <= fwd_b;
            exmem_rd         <= idex_rd;
            memwb_reg_write  <= exmem_reg_write;
            memwb_mem_to_reg <= exmem_mem_to_reg;
            memwb_alu        <= exmem_alu;
            memwb_ld         <= dmem[exmem_alu[DW+1:2]];
            memwb_rd         <= exmem_rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_i && memwb_reg_write && memwb_rd != 5'd0)
            rf[memwb_rd] <= wb_val;
    end

    always_ff @(posedge clk_i) begin
        if (start_i && exmem_mem_write)
            dmem[exmem_alu[DW+1:2]] <= exmem_sd;
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (start_i) begin
            if (load_use)          stall_cnt_o <= stall_cnt_o + 32'd1;
            else if (branch_taken) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_riscv5_pipe_cpu.sv
// Bench for riscv5_pipe_cpu: directed programs; expected register writes are queued and checked at WB.
module tb_riscv5_pipe_cpu;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i;
    logic [31:0] pc_o;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    riscv5_pipe_cpu dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .pc_o    (pc_o)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    wb_t         exp_q[$];
    wb_t         e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          first_wb_cyc = -1;
    int          stalls = 0;
    logic        cnt_en = 1'b0;
    logic [31:0] prev_pc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] srai(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] sh);
        return {7'b0100000, sh, rs1, 3'b101, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    always @(posedge clk_i) if (rst_i && start_i) cyc = cyc + 1;

    // Monitor: every cycle the core runs, a WB register write must match the queue head.
    always @(negedge clk_i) begin
        if (rst_i && start_i) begin
            if (cnt_en) begin
                if (pc_o == prev_pc) stalls++;
                prev_pc = pc_o;
            end
            if (dut.memwb_reg_write && dut.memwb_rd != 5'd0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_wb: got x%0d=%h expected no write", dut.memwb_rd, dut.wb_val);
                end else begin
                    e = exp_q.pop_front();
                    if (first_wb_cyc < 0) first_wb_cyc = cyc;
                    check("wb_rd", 32'(dut.memwb_rd), 32'(e.rd));
                    check("wb_val", dut.wb_val, e.val);
                end
            end
        end
    end

    task automatic push(input logic [4:0] rd, input logic [31:0] val);
        exp_q.push_back({rd, val});
    endtask

    task automatic load(input logic [31:0] prog[$]);
        rst_i   = 1'b0;
        start_i = 1'b0;
        cnt_en  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
        for (int r = 0; r < 32; r++)  dut.rf[r] = 32'h0;
        for (int d = 0; d < 32; d++)  dut.dmem[d] = 32'h0;
    endtask

    task automatic run_prog(input int ncyc);
        @(negedge clk_i);
        #1;
        cyc = 0;
        first_wb_cyc = -1;
        stalls = 0;
        prev_pc = 32'h0;
        cnt_en = 1'b1;
        rst_i = 1'b1;
        start_i = 1'b1;
        repeat (ncyc) @(posedge clk_i);
        #1;
        start_i = 1'b0;
        cnt_en = 1'b0;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_wb: got %0d writes outstanding expected 0", exp_q.size());
        end
    endtask

    logic [31:0] p[$];

    initial begin
        rst_i = 1'b0;
        start_i = 1'b0;
        #2;
        check("reset_pc", pc_o, 32'h0);
        check("reset_ifid", dut.ifid_instr, 32'h0);

        // Load-use: one stall, x2 = 5 + 5
        p = '{lw(1, 0, 0), r_t(7'b0, 3'b000, 2, 1, 1)};
        load(p);
        dut.dmem[0] = 32'd5;
        push(1, 32'd5); push(2, 32'd10);
        run_prog(12);
        check("lu_x2", dut.rf[2], 32'd10);
        check("lu_stalls", 32'(stalls), 32'd1);
`ifdef PERF_CNT_EN
        check("lu_stall_cnt", stall_cnt_o, 32'd1);
`endif

        // Forwarding from EX/MEM and MEM/WB, no stall, 5-cycle write latency
        p = '{addi(1, 0, 12'd3), addi(2, 1, 12'd4), r_t(7'b0100000, 3'b000, 3, 2, 1)};
        load(p);
        push(1, 32'd3); push(2, 32'd7); push(3, 32'd4);
        run_prog(12);
        check("fw_x3", dut.rf[3], 32'd4);
        check("fw_stalls", 32'(stalls), 32'd0);
        check("fw_latency", 32'(first_wb_cyc), 32'd4);
`ifdef PERF_CNT_EN
        check("fw_stall_cnt", stall_cnt_o, 32'd0);
`endif

        // Taken branch skips addi x5
        p = '{addi(1, 0, 12'd1), 32'h0, 32'h0, 32'h0, beq(1, 1, 13'd8), addi(5, 0, 12'd9), addi(6, 0, 12'd2)};
        load(p);
        push(1, 32'd1); push(6, 32'd2);
        run_prog(16);
        check("bt_x5", dut.rf[5], 32'd0);
        check("bt_x6", dut.rf[6], 32'd2);
`ifdef PERF_CNT_EN
        check("bt_flush_cnt", flush_cnt_o, 32'd1);
`endif

        // Not-taken branch: x1 != x0
        p = '{addi(1, 0, 12'd1), 32'h0, 32'h0, 32'h0, beq(1, 0, 13'd8), addi(5, 0, 12'd9), addi(6, 0, 12'd2)};
        load(p);
        push(1, 32'd1); push(5, 32'd9); push(6, 32'd2);
        run_prog(16);
        check("bn_x5", dut.rf[5], 32'd9);
        check("bn_stalls", 32'(stalls), 32'd0);
`ifdef PERF_CNT_EN
        check("bn_flush_cnt", flush_cnt_o, 32'd0);
`endif

        // Store/load and ALU mix
        p = '{addi(1, 0, 12'hFF8), srai(2, 1, 5'd1), addi(3, 0, 12'd3),
              r_t(7'b0000001, 3'b000, 4, 3, 3), sw(4, 0, 12'd4), lw(5, 0, 12'd4),
              r_t(7'b0, 3'b100, 6, 5, 3), r_t(7'b0, 3'b111, 7, 4, 3), r_t(7'b0, 3'b001, 8, 3, 3)};
        load(p);
        push(1, 32'hFFFF_FFF8); push(2, 32'hFFFF_FFFC); push(3, 32'd3); push(4, 32'd9);
        push(5, 32'd9); push(6, 32'd10); push(7, 32'd1); push(8, 32'd24);
        run_prog(20);
        check("alu_x2", dut.rf[2], 32'hFFFF_FFFC);
        check("alu_dmem1", dut.dmem[1], 32'd9);
        check("alu_x8", dut.rf[8], 32'd24);
        check("alu_stalls", 32'(stalls), 32'd1);

        // x0 protection
        p = '{addi(0, 0, 12'd7), r_t(7'b0, 3'b000, 1, 0, 0)};
        load(p);
        dut.rf[1] = 32'd55;
        push(1, 32'd0);
        run_prog(10);
        check("x0_rf0", dut.rf[0], 32'd0);
        check("x0_x1", dut.rf[1], 32'd0);

        // Asynchronous reset mid-program
        p = '{addi(1, 0, 12'd3), addi(2, 1, 12'd4), r_t(7'b0100000, 3'b000, 3, 2, 1)};
        load(p);
        dut.dmem[3] = 32'h1234;
        push(1, 32'd3); push(2, 32'd7);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        start_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        check("mid_pc_before", pc_o, 32'd24);
        #1;
        rst_i = 1'b0;
        #1;
        check("mid_pc_async", pc_o, 32'h0);
        check("mid_memwb_we", 32'(dut.memwb_reg_write), 32'h0);
        check("mid_ifid_pc", dut.ifid_pc, 32'h0);
        check("mid_x2", dut.rf[2], 32'd7);
        check("mid_x3", dut.rf[3], 32'd0);
        check("mid_dmem3", dut.dmem[3], 32'h1234);
        check("mid_queue", 32'(exp_q.size()), 32'd0);
        start_i = 1'b0;

        // start_i = 0 holds PC
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("hold_pc", pc_o, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
